// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the mode-0 SPI slave.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Bit counter width; a 1-bit frame still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Serial pins plus the TX/RX byte handshakes of the SPI slave.
// Handshakes: a transfer happens on a clk edge where valid && ready are both 1;
// valid holds its data stable until that edge, ready may change freely.
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
    output miso, tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
    input  miso, tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Pin synchronizer plus delay flop; the level output is aligned with the
// registered rise/fall strobes so data sampled on a strobe is consistent.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_dly  <= w_synced;
      r_rise <= w_synced & ~r_dly;
      r_fall <= ~w_synced & r_dly;
    end
  end

  assign o_level = r_dly;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 MSB-first SPI slave running entirely in the clk domain.
// Optional SPI_SLAVE_OVR_EN adds ovr_err (RX drop / TX zero-fill pulse).
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_slave_if.slave  bus,
`ifdef SPI_SLAVE_OVR_EN
  output logic        ovr_err,
`endif
  output state_t      dbg_state
);

  localparam int              CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
  logic w_cs_rise, w_cs_fall, w_cs_level_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (bus.sclk),
    .o_level (w_sclk_level_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (bus.cs_n),
    .o_level (w_cs_level_unused),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (bus.mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  state_t             r_state;
  logic [DATA_W-1:0]  r_tx_buf;
  logic               r_tx_full;
  logic [DATA_W-1:0]  r_tx_shreg;
  logic [DATA_W-1:0]  r_rx_shreg;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_byte_done;
  logic [DATA_W-1:0]  r_rx_data;
  logic               r_rx_valid;

  logic               w_active;
  logic               w_frame_start;
  logic               w_frame_end;
  logic               w_in_frame;
  logic               w_load;
  logic               w_shift_out;
  logic               w_shift_in;
  logic               w_complete;
  logic               w_rx_accept;
  logic               w_tx_write;
  logic [DATA_W-1:0]  w_rx_byte;

  assign w_active      = (r_state == ACTIVE);
  assign w_frame_start = (r_state == IDLE) && w_cs_fall;
  assign w_frame_end   = w_active && w_cs_rise;
  assign w_in_frame    = w_active && !w_cs_rise;

  // The fall after the last rise of a byte reloads instead of shifting.
  assign w_load      = w_frame_start || (w_in_frame && w_sclk_fall && r_byte_done);
  assign w_shift_out = w_in_frame && w_sclk_fall && !r_byte_done;
  assign w_shift_in  = w_in_frame && w_sclk_rise;
  assign w_complete  = w_shift_in && (r_bit_cnt == LAST);
  assign w_rx_accept = r_rx_valid && bus.rx_ready;
  assign w_tx_write  = bus.tx_valid && !r_tx_full;
  assign w_rx_byte   = {r_rx_shreg[DATA_W-2:0], w_mosi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_tx_shreg  <= '0;
      r_rx_shreg  <= '0;
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall) r_state <= ACTIVE;
        ACTIVE:  if (w_cs_rise) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Load empties the buffer; a write can only land while it is empty.
      if (w_load)     r_tx_full <= 1'b0;
      if (w_tx_write) begin
        r_tx_full <= 1'b1;
        r_tx_buf  <= bus.tx_data;
      end

      if (w_load)           r_tx_shreg <= r_tx_full ? r_tx_buf : '0;
      else if (w_shift_out) r_tx_shreg <= {r_tx_shreg[DATA_W-2:0], 1'b0};

      if (w_frame_start || w_frame_end) begin
        r_rx_shreg  <= '0;
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
      end else begin
        if (w_shift_in) begin
          r_rx_shreg <= w_rx_byte;
          r_bit_cnt  <= (r_bit_cnt == LAST) ? '0 : r_bit_cnt + CNT_W'(1);
        end
        if (w_complete)                     r_byte_done <= 1'b1;
        else if (w_sclk_fall && w_in_frame) r_byte_done <= 1'b0;
      end

      // A byte completing in the acceptance cycle replaces the accepted one.
      if (w_rx_accept) r_rx_valid <= 1'b0;
      if (w_complete && (!r_rx_valid || bus.rx_ready)) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_OVR_EN
  logic r_ovr;
  logic w_drop;

  assign w_drop = w_complete && r_rx_valid && !bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovr <= 1'b0;
    else        r_ovr <= w_drop || (w_load && !r_tx_full);
  end

  assign ovr_err = r_ovr;
`endif

  assign bus.miso     = w_active & r_tx_shreg[DATA_W-1];
  assign bus.tx_ready = ~r_tx_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = w_active;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model drives the serial pins.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   g_rv_lat;
  int   ovr_cnt = 0;
  int   tx_low_cnt = 0;

  spi_slave_if #(.DATA_W(8)) bus ();
  state_t dbg_state;
`ifdef SPI_SLAVE_OVR_EN
  logic ovr_err;
`endif

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
`ifdef SPI_SLAVE_OVR_EN
    .ovr_err   (ovr_err),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
`ifdef SPI_SLAVE_OVR_EN
    if (ovr_err === 1'b1) ovr_cnt++;
`endif
    if (rst_n && bus.tx_ready !== 1'b1) tx_low_cnt++;
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = mo[7-i];
      wait_clk(HALF);
      bus.sclk = 1'b1;
      mi[7-i] = bus.miso;
      if (i == 7) begin
        g_rv_lat = (bus.rx_valid === 1'b1) ? -1 : 0;
        for (int k = 1; k <= HALF; k++) begin
          @(posedge clk);
          #1;
          if (g_rv_lat == 0 && bus.rx_valid === 1'b1) g_rv_lat = k;
        end
      end else begin
        wait_clk(HALF);
      end
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    bus.cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    bus.cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic tx_push(input logic [7:0] d);
    int t;
    t = 0;
    while (bus.tx_ready !== 1'b1 && t < 100) begin
      wait_clk(1);
      t++;
    end
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_push_wait got tx_ready=%b exp 1 within 100 cycles", bus.tx_ready);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic rx_ack();
    bus.rx_ready = 1'b1;
    wait_clk(1);
    bus.rx_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    logic [7:0] mi;
    wait_clk(3);
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b exp 0", bus.miso); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b exp 1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    wait_clk(4);

    tx_push(8'h5A);
    cs_start();
    tx_push(8'h66);
    spi_bits(8'hE0, 3, mi);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b exp 1", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL midframe_tx_ready got %b exp 0", bus.tx_ready); end
    rst_n = 1'b0;
    #2;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL mrst_tx_ready got %b exp 1", bus.tx_ready); end
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL mrst_miso got %b exp 0", bus.miso); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL mrst_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mrst_state got %0d exp %0d", dbg_state, IDLE); end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);

    tx_push(8'hB4);
    cs_start();
    spi_bits(8'hC3, 8, mi);
    cs_end();
    checks++; if (mi !== 8'hB4) begin errors++; $display("FAIL post_rst_master_rx got %h exp b4", mi); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL post_rst_rx_valid got %b exp 1", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'hC3) begin errors++; $display("FAIL post_rst_rx_data got %h exp c3", bus.rx_data); end
    rx_ack();
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL post_rst_ack got %b exp 0", bus.rx_valid); end
  endtask

  task automatic test_single_byte();
    logic [7:0] mi;
    tx_push(8'hA5);
    cs_start();
    spi_bits(8'h3C, 8, mi);
    checks++; if (g_rv_lat !== 4) begin errors++; $display("FAIL rx_valid_latency got %0d exp 4", g_rv_lat); end
    cs_end();
    checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL single_master_rx got %h exp a5", mi); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data got %h exp 3c", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL single_rx_valid got %b exp 1", bus.rx_valid); end
    rx_ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] m0, m1;
    tx_push(8'h81);
    cs_start();
    tx_push(8'h7E);
    spi_bits(8'hC5, 8, m0);
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_rx_valid0 got %b exp 1", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'hC5) begin errors++; $display("FAIL b2b_rx_data0 got %h exp c5", bus.rx_data); end
    rx_ack();
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack0 got %b exp 0", bus.rx_valid); end
    spi_bits(8'h3A, 8, m1);
    cs_end();
    checks++; if (m0 !== 8'h81) begin errors++; $display("FAIL b2b_miso0 got %h exp 81", m0); end
    checks++; if (m1 !== 8'h7E) begin errors++; $display("FAIL b2b_miso1 got %h exp 7e", m1); end
    checks++; if (bus.rx_data !== 8'h3A) begin errors++; $display("FAIL b2b_rx_data1 got %h exp 3a", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_rx_valid1 got %b exp 1", bus.rx_valid); end
    rx_ack();
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack1 got %b exp 0", bus.rx_valid); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    cs_start();
    spi_bits(8'hFF, 5, mi);
    cs_end();
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    cs_start();
    spi_bits(8'h12, 8, mi);
    cs_end();
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL abort_next_valid got %b exp 1", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h12) begin errors++; $display("FAIL abort_next_data got %h exp 12", bus.rx_data); end
    rx_ack();
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    int base;
    base = ovr_cnt;
    tx_push(8'hAA);
    cs_start();
    tx_push(8'hBB);
    spi_bits(8'h11, 8, mi);
    cs_end();
    tx_push(8'hCC);
    cs_start();
    tx_push(8'hDD);
    spi_bits(8'h22, 8, mi);
    cs_end();
    checks++; if (bus.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_rx_data got %h exp 11", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid got %b exp 1", bus.rx_valid); end
    checks++; if (mi !== 8'hCC) begin errors++; $display("FAIL ovr_master_rx got %h exp cc", mi); end
`ifdef SPI_SLAVE_OVR_EN
    checks++; if (ovr_cnt - base !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - base); end
`endif
    rx_ack();
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack got %b exp 0", bus.rx_valid); end
  endtask

  task automatic test_empty_tx();
    logic [7:0] mi;
    int base_low, base_ovr;
    base_low = tx_low_cnt;
    base_ovr = ovr_cnt;
    cs_start();
    spi_bits(8'h99, 8, mi);
    cs_end();
    checks++; if (mi !== 8'h00) begin errors++; $display("FAIL empty_master_rx got %h exp 00", mi); end
    checks++; if (tx_low_cnt - base_low !== 0) begin errors++; $display("FAIL empty_tx_ready_low got %0d cycles exp 0", tx_low_cnt - base_low); end
    checks++; if (bus.rx_data !== 8'h99) begin errors++; $display("FAIL empty_rx_data got %h exp 99", bus.rx_data); end
`ifdef SPI_SLAVE_OVR_EN
    checks++; if (ovr_cnt - base_ovr !== 2) begin errors++; $display("FAIL empty_ovr_pulses got %0d exp 2", ovr_cnt - base_ovr); end
`endif
    rx_ack();
  endtask

  initial begin
    bus.sclk     = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_empty_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave that sits directly downstream of the SPI master on the same serial bus. It consumes sclk/cs_n/mosi and drives miso. All logic runs in the system clk domain, with the serial pins oversampled through synchronizers. It is the loop-back partner for master-side tests and the serial front end for on-chip register targets.

## Interface
- DATA_W, 8, bits per frame
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs_n and mosi (≥2)
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  serial clock from master, idle low
- cs_n  in  1  active-low chip select
- mosi  in  1  serial data from master
- miso  out  1  serial data to master
- tx_data  in  DATA_W  next byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  one-entry TX holding buffer empty
- rx_data  out  DATA_W  last received byte
- rx_valid  out  1  rx_data valid, held until accepted
- rx_ready  in  1  consumer accepts rx_data
- busy  out  1  frame in progress (state ACTIVE)

## Operation
- sclk, cs_n and mosi each pass through SYNC_STAGES flops, plus one delay flop for edge detection. rise, fall, cs_fall and cs_rise are single-cycle strobes. mosi is delayed identically, so it stays aligned with sclk.
- States: IDLE, ACTIVE.
  - IDLE→ACTIVE on cs_fall.
  - ACTIVE→IDLE on cs_rise.
- TX holding buffer:
  - tx_valid && tx_ready writes tx_data to the buffer and clears tx_ready.
  - A load point takes the buffer and sets tx_ready.
  - If the buffer is empty at a load point, 0x00 is loaded.
- Load points:
  - cs_fall.
  - The fall strobe that follows the DATA_W-th rise of a byte while cs_n is still low.
- Shift-out: miso = tx_shreg[DATA_W-1] while ACTIVE, 0 in IDLE. Each non-load fall shifts tx_shreg left by 1.
- Shift-in: each rise shifts the synchronized mosi into the LSB of rx_shreg and increments bit_cnt (width clog2(DATA_W), wraps to 0 after DATA_W-1).
- Byte complete: on the rise that wraps bit_cnt to 0:
  - If rx_valid is 0: rx_data ← completed byte, rx_valid ← 1.
  - If rx_valid is 1: the byte is dropped, and rx_data/rx_valid are unchanged.
- rx_valid && rx_ready clears rx_valid next cycle. If a byte completes in the same cycle as acceptance, the new byte wins and rx_valid stays 1.
- cs_rise mid-byte aborts the frame:
  - Partial rx bits are discarded, bit_cnt ← 0, no rx_valid.
  - The TX buffer is untouched.
- A rise or fall strobe while in IDLE is ignored.
- Reset values: miso 0, tx_ready 1, rx_data 0, rx_valid 0, busy 0; state IDLE, bit_cnt 0, shift registers 0.

## Timing
- Detection latency: a pin change is seen as a strobe SYNC_STAGES+1 clk edges after the first clk edge that samples it.
- rx_valid rises SYNC_STAGES+2 clk edges after clk first samples the final sclk rise of a byte.
- miso updates SYNC_STAGES+2 clk edges after clk samples a sclk fall or a cs_n fall.
- Constraints on the master:
  - sclk half period ≥ 2·(SYNC_STAGES+2) clk cycles.
  - cs_n-fall to first sclk-rise setup ≥ 2·(SYNC_STAGES+2) clk cycles.
  - cs_n must stay high ≥ SYNC_STAGES+2 cycles between frames.
- tx_ready reasserts the cycle after a load point consumes the buffer.

## Configuration
- SPI_SLAVE_OVR_EN defined:
  - Adds output ovr_err (1 bit, reset 0).
  - ovr_err pulses for one cycle when a completed byte is dropped because rx_valid=1.
  - ovr_err also pulses for one cycle when a load point finds the TX buffer empty.
- SPI_SLAVE_OVR_EN undefined: no port and no logic; drops and zero-fills happen silently.

## Structure
- spi_slave_pkg:
  - state_t enum {IDLE, ACTIVE}.
  - DATA_W_DEF = 8.
  - SYNC_STAGES_DEF = 2.
- Sub-module spi_sync_edge (parameter SYNC_STAGES): synchronizer plus delay flop. Outputs are the synced level plus rise and fall strobes.
  - Instantiated for sclk and cs_n.
  - mosi uses the level output only.

## Test plan
- Reset mid-frame (cs_n low, 3 bits shifted), then release: every output at its reset value, state IDLE, the next frame receives cleanly.
- Buffer 0xA5, master sends 0x3C with divider 8: master rx_data=0xA5; slave rx_valid=1 with rx_data=0x3C, SYNC_STAGES+2 cycles after the 8th rise.
- Two-byte frame, cs_n held low, tx 0x81 then 0x7E written before the 8th fall: miso sequence 10000001 01111110; two rx_valid pulses, each acknowledged with rx_ready.
- cs_n rises after 5 bits of 0xFF: no rx_valid; the next full frame with 0x12 yields rx_data=0x12.
- rx_ready held 0 across two frames sending 0x11 then 0x22: rx_data stays 0x11; with SPI_SLAVE_OVR_EN, ovr_err pulses once.
- Empty TX buffer at cs_fall: master receives 0x00; tx_ready stays 1 throughout.
